uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered UART transmitter. Accepts bytes from core logic through a write-enable FIFO interface and serializes them onto the UART line as 8-bit frames. Frame format is 8N1 by default, with optional parity and two stop bits. It pairs with the board's UART receiver at the same baud. It lets the host stream multi-byte responses back-to-back without per-byte handshaking.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer truncation, 10416 at defaults)
FIFO_DEPTH, 16, byte entries; power of two, at least 2
PARITY_EN, 0, 1 = insert parity bit after data bits
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd
STOP_BITS, 1, number of stop bits: 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
wr_data  in  8  byte to enqueue
wr_en  in  1  enqueue request, sampled on rising clk
full  out  1  FIFO holds FIFO_DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the byte in the shifter
overflow  out  1  one-cycle pulse when a write is dropped
busy  out  1  a frame is on the line (state != IDLE)
tx  out  1  UART serial output, idle high, registered

Behaviour:
- Reset (async, rst_n low):
  - tx=1, busy=0, empty=1, full=0, level=0, overflow=0.
  - FIFO pointers are cleared and contents discarded.
  - Reset mid-frame forces tx high immediately, with no completion of the frame.
- FIFO write:
  - Accepted iff wr_en=1 and full=0, using full as registered at that edge.
  - Accepted: level increments, unless a pop occurs on the same edge, in which case level is unchanged.
  - wr_en=1 while full=1: byte dropped, contents unchanged, overflow=1 for exactly the next cycle.
  - A pop on the same edge does not rescue a write while full.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit timer counts 0..BIT_CYCLES-1, so each line bit is held exactly BIT_CYCLES clocks.
- IDLE:
  - If empty=0: pop the FIFO head into the shift register, go to START, tx<=0, timer cleared.
  - Latency: wr_en sampled at edge N into an empty FIFO with the FSM idle makes tx low after edge N+1.
  - There is no bypass path.
- START: after BIT_CYCLES, go to DATA with bit index 0, tx<=data[0].
- DATA:
  - Bits are sent LSB first, each held BIT_CYCLES.
  - After bit 7: go to PARITY if PARITY_EN, else go to STOP with tx<=1.
- PARITY: tx = ^data for even parity, ~^data for odd; held BIT_CYCLES, then go to STOP with tx<=1.
- STOP:
  - tx=1 for STOP_BITS*BIT_CYCLES clocks.
  - On the final cycle, if empty=0: pop the next byte and enter START directly. There is no idle gap, and the next start bit begins the cycle immediately after the last stop cycle.
  - Otherwise go to IDLE.
- Frame length is (1+8+PARITY_EN+STOP_BITS)*BIT_CYCLES clocks; 104160 at defaults.
- busy=1 from the first start-bit cycle through the last stop-bit cycle.
- Pointers wrap modulo FIFO_DEPTH. full and empty are derived from level; level never exceeds FIFO_DEPTH.
- A write arriving during a frame is queued and never alters the byte being shifted.

Test Plan:
Bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CYCLES=10), FIFO_DEPTH=4.
1. Reset, then write 0xA5 once -> tx low 1 clock after the write edge. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 clocks. busy high for 100 clocks, then empty=1, busy=0, tx=1.
2. Write 0x00, 0xFF, 0x55 on consecutive clocks -> level peaks at 2. Three frames back-to-back with zero idle clocks between the stop bit and the next start bit. Bytes decode in order.
3. While frame 1 is shifting, write 5 more bytes -> full=1 after the 4th write. The 5th write gives an overflow pulse of 1 cycle and is dropped. Exactly 5 frames are sent in total.
4. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte 0x07 -> parity bit 1, then stop high for 20 clocks; frame is 120 clocks. With PARITY_ODD=1, parity bit is 0.
5. With full=1, assert wr_en on the same edge as a pop at stop completion -> write dropped, overflow pulses, level drops to 3.
6. Assert rst_n low mid-DATA of 0x3C with 2 bytes queued -> tx=1 immediately, busy=0, empty=1, level=0. After release, no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-write port of the buffered UART transmitter: enqueue handshake plus FIFO status.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (output wr_data, wr_en, input full, empty, level, overflow);
  modport slave  (input wr_data, wr_en, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a frame serializer (8 data bits, optional parity, 1-2 stops).
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  wr_if,
  output logic           busy,
  output logic           tx
);
  localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int unsigned TW          = $clog2(STOP_CYCLES + 1);
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned LW          = PW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          busy_q;

  logic empty_c, full_c, wr_accept_c, pop_c, bit_done_c, stop_done_c, parity_c;

  assign empty_c     = (level_q == '0);
  assign full_c      = (level_q == LW'(FIFO_DEPTH));
  assign wr_accept_c = wr_if.wr_en && !full_c;
  assign bit_done_c  = (timer_q == TW'(BIT_CYCLES - 1));
  assign stop_done_c = (timer_q == TW'(STOP_CYCLES - 1));
  assign parity_c    = (^sh_q) ^ (PARITY_ODD != 0);

  // The head byte leaves the FIFO when idle, or on the last stop cycle for a gapless next frame.
  always_comb begin
    pop_c = 1'b0;
    if (!empty_c) begin
      if (state_q == IDLE) pop_c = 1'b1;
      else if (state_q == STOP && stop_done_c) pop_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept_c) mem[wr_ptr_q] <= wr_if.wr_data;
  end

  // Pointers and occupancy; a write while full is dropped even if a pop happens on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_if.wr_en && full_c;
      if (wr_accept_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)       rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_accept_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame serializer; tx and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty_c) begin
            sh_q    <= mem[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_done_c) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= sh_q[0];
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (bit_done_c) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_c;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= sh_q[bit_idx_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        PARITY: begin
          if (bit_done_c) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (stop_done_c) begin
            timer_q <= '0;
            if (!empty_c) begin
              sh_q    <= mem[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_if.full     = full_c;
  assign wr_if.empty    = empty_c;
  assign wr_if.level    = level_q;
  assign wr_if.overflow = overflow_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: 8N1 instance plus even/odd parity instances with two stop bits.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) m_if ();
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) pe_if ();
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) po_if ();

  logic m_busy, m_tx, pe_busy, pe_tx, po_busy, po_tx;
  logic [7:0] p_data;
  logic       p_en;

  assign pe_if.wr_data = p_data;
  assign pe_if.wr_en   = p_en;
  assign po_if.wr_data = p_data;
  assign po_if.wr_en   = p_en;

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut (.clk(clk), .rst_n(rst_n), .wr_if(m_if), .busy(m_busy), .tx(m_tx));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    dut_pe (.clk(clk), .rst_n(rst_n), .wr_if(pe_if), .busy(pe_busy), .tx(pe_tx));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH),
                 .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut_po (.clk(clk), .rst_n(rst_n), .wr_if(po_if), .busy(po_busy), .tx(po_tx));

  typedef struct {
    logic [7:0] d;
    logic       p_even;
    logic       p_odd;
  } pexp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  pexp_t      pexp_q[$];
  longint     start_q[$];
  longint     p_start_q[$];
  longint     cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 8N1 line: decodes each frame mid-bit and retires the scoreboard head.
  int         m_cnt = 0;
  bit         m_act = 0;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_act = 0;
    end else if (!m_act) begin
      if (m_tx == 1'b0) begin
        m_act = 1;
        m_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 5) chk("start_bit", m_tx, 0);
      else if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt - 15) % 10 == 0)
        m_byte[3'((m_cnt - 15) / 10)] = m_tx;
      else if (m_cnt == 95) begin
        chk("stop_bit", m_tx, 1);
        chk("busy_in_frame", m_busy, 1);
        chk("frame_was_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("frame_byte", m_byte, exp_q.pop_front());
      end
      if (m_cnt == 99) m_act = 0;
    end
  end

  // Monitor for the two parity instances, which are driven identically and run in lockstep.
  int         p_cnt = 0;
  bit         p_act = 0;
  logic [7:0] pe_byte, po_byte;
  logic       pe_par, po_par;
  pexp_t      pe;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_act = 0;
    end else if (!p_act) begin
      if (pe_tx == 1'b0) begin
        p_act = 1;
        p_cnt = 0;
        p_start_q.push_back(cyc);
        chk("odd_inst_start_aligned", po_tx, 0);
      end
    end else begin
      p_cnt = p_cnt + 1;
      if (p_cnt >= 15 && p_cnt <= 85 && (p_cnt - 15) % 10 == 0) begin
        pe_byte[3'((p_cnt - 15) / 10)] = pe_tx;
        po_byte[3'((p_cnt - 15) / 10)] = po_tx;
      end else if (p_cnt == 95) begin
        pe_par = pe_tx;
        po_par = po_tx;
      end else if (p_cnt == 105 || p_cnt == 115) begin
        chk("p_even_stop", pe_tx, 1);
        chk("p_odd_stop", po_tx, 1);
      end
      if (p_cnt == 115) begin
        chk("pframe_was_queued", pexp_q.size() > 0, 1);
        if (pexp_q.size() > 0) begin
          pe = pexp_q.pop_front();
          chk("p_even_byte", pe_byte, pe.d);
          chk("p_odd_byte", po_byte, pe.d);
          chk("p_even_parity", pe_par, pe.p_even);
          chk("p_odd_parity", po_par, pe.p_odd);
        end
      end
      if (p_cnt == 119) p_act = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One write on the next edge; returns 1 time unit after that edge.
  task automatic wr(input logic [7:0] d, input bit acc);
    m_if.wr_en   = 1'b1;
    m_if.wr_data = d;
    if (acc) exp_q.push_back(d);
    step(1);
    m_if.wr_en = 1'b0;
    chk("overflow_after_write", m_if.overflow, !acc);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    step(2);
    while ((m_busy || !m_if.empty) && n < 2000) begin
      step(1);
      n++;
    end
    chk({nm, "_idle_in_time"}, n < 2000, 1);
    step(2);
    chk({nm, "_scoreboard_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_if.wr_en   = 1'b0;
    m_if.wr_data = '0;
    p_en         = 1'b0;
    p_data       = '0;

    // Reset values
    step(3);
    chk("rst_tx", m_tx, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_empty", m_if.empty, 1);
    chk("rst_full", m_if.full, 0);
    chk("rst_level", m_if.level, 0);
    chk("rst_overflow", m_if.overflow, 0);
    rst_n = 1'b1;
    step(2);

    // 1: single byte 0xA5, latency and busy duration
    wr(8'hA5, 1);
    chk("t1_tx_before_start", m_tx, 1);
    chk("t1_level_after_write", m_if.level, 1);
    step(1);
    chk("t1_tx_low_next_edge", m_tx, 0);
    chk("t1_level_after_pop", m_if.level, 0);
    n = 0;
    while (m_busy && n < 300) begin
      n++;
      step(1);
    end
    chk("t1_busy_cycles", n, 100);
    chk("t1_empty_end", m_if.empty, 1);
    chk("t1_tx_idle_end", m_tx, 1);
    wait_idle("t1");

    // 2: three consecutive writes, gapless frames
    start_q.delete();
    wr(8'h00, 1);
    chk("t2_level_w1", m_if.level, 1);
    wr(8'hFF, 1);
    chk("t2_level_w2", m_if.level, 1);
    wr(8'h55, 1);
    chk("t2_level_w3", m_if.level, 2);
    wait_idle("t2");
    chk("t2_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("t2_gap_1_2", start_q[1] - start_q[0], 100);
      chk("t2_gap_2_3", start_q[2] - start_q[1], 100);
    end

    // 3: fill the FIFO behind a running frame, fifth extra write overflows
    start_q.delete();
    wr(8'h11, 1);
    step(3);
    wr(8'h22, 1);
    chk("t3_level_1", m_if.level, 1);
    wr(8'h33, 1);
    wr(8'h44, 1);
    wr(8'h66, 1);
    chk("t3_level_full", m_if.level, 4);
    chk("t3_full", m_if.full, 1);
    wr(8'h77, 0);
    chk("t3_level_after_drop", m_if.level, 4);
    step(1);
    chk("t3_overflow_one_cycle", m_if.overflow, 0);
    wait_idle("t3");
    chk("t3_frames", start_q.size(), 5);

    // 5: write while full on the same edge as the stop-completion pop
    start_q.delete();
    wr(8'h81, 1);
    wr(8'h42, 1);
    wr(8'h24, 1);
    wr(8'h18, 1);
    wr(8'hE7, 1);
    chk("t5_full", m_if.full, 1);
    step(96);
    wr(8'h99, 0);
    chk("t5_level_after_pop", m_if.level, 3);
    chk("t5_not_full", m_if.full, 0);
    chk("t5_next_start", m_tx, 0);
    step(1);
    chk("t5_overflow_clear", m_if.overflow, 0);
    wait_idle("t5");
    chk("t5_frames", start_q.size(), 5);

    // 4: parity instances, 0x07 then 0x3C with two stop bits
    p_start_q.delete();
    pexp_q.push_back('{d: 8'h07, p_even: 1'b1, p_odd: 1'b0});
    pexp_q.push_back('{d: 8'h3C, p_even: 1'b0, p_odd: 1'b1});
    p_en   = 1'b1;
    p_data = 8'h07;
    step(1);
    p_data = 8'h3C;
    step(1);
    p_en = 1'b0;
    n = 0;
    while (pe_busy && n < 1000) begin
      n++;
      step(1);
    end
    chk("t4_busy_two_frames", n, 240);
    chk("t4_odd_inst_idle", po_busy, 0);
    step(3);
    chk("t4_pframes", p_start_q.size(), 2);
    if (p_start_q.size() == 2) chk("t4_frame_len", p_start_q[1] - p_start_q[0], 120);
    chk("t4_scoreboard_drained", pexp_q.size(), 0);

    // 6: reset mid-DATA with bytes queued
    start_q.delete();
    wr(8'h3C, 1);
    wr(8'h5A, 1);
    wr(8'hC3, 1);
    step(30);
    chk("t6_busy_before_rst", m_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", m_tx, 1);
    chk("t6_rst_busy", m_busy, 0);
    chk("t6_rst_empty", m_if.empty, 1);
    chk("t6_rst_level", m_if.level, 0);
    exp_q.delete();
    start_q.delete();
    step(3);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (m_tx == 1'b0) n++;
    end
    chk("t6_tx_low_cycles_after_rst", n, 0);
    chk("t6_frames_after_rst", start_q.size(), 0);
    chk("t6_busy_after_rst", m_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
